// File: rtl/decoder_sched.sv
// Round-robin scheduler sharing one decoder among four requesters over a four-phase req/ack handshake.
// Optional ack-wait timeout with sticky err: define DECODER_SCHED_TIMEOUT_EN.
module decoder_sched #(
  parameter int N_REQ   = 4,
  parameter int DW      = 7,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [DW-1:0]      dec_data,
  output logic               dec_req,
  input  logic               dec_ack,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // The arbiter uses a 2-bit pointer; any other requester count or a zero limit is unusable.
  if (N_REQ != 4 || TIMEOUT < 1) begin : g_bad_params
    $fatal(1, "decoder_sched: N_REQ must be 4 and TIMEOUT must be at least 1");
  end

  state_t     state;
  logic [1:0] last_grant;
  logic [1:0] win_id;
  logic       win_any;
  logic       accept;
  logic       ack_m;
  logic       ack_s;
  logic       tmo;

  // dec_ack comes from another timing domain; only the second flop feeds the FSM.
  // NOTE: sequential state uses <= so every flop samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= dec_ack;
      ack_s <= ack_m;
    end
  end

  // Search starts one past the previous winner; k = 4 wraps back to last_grant itself.
  // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    win_any = 1'b0;
    win_id  = last_grant;
    for (int k = 1; k <= 4; k++) begin
      if (!win_any && req_valid[2'(last_grant + 2'(k))]) begin
        win_any = 1'b1;
        win_id  = 2'(last_grant + 2'(k));
      end
    end
  end

  assign accept    = (state == IDLE) && win_any;
  assign req_ready = accept ? (N_REQ'(1) << win_id) : '0;
  assign busy      = (state != IDLE);

`ifdef DECODER_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;
  logic          err_q;

  // Fires on the TIMEOUT-th cycle spent in WAIT_ACK without a synchronized ack.
  assign tmo = (state == WAIT_ACK) && !ack_s && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt <= '0;
      end else if (state == WAIT_ACK) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // NOTE: every register here is reset, since dec_data/grant_id are visible outputs from reset on.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dec_req    <= 1'b0;
      dec_data   <= '0;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dec_data   <= req_data[int'(win_id) * DW +: DW];
            grant_id   <= win_id;
            last_grant <= win_id;
            dec_req    <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s || tmo) begin
            dec_req <= 1'b0;
            state   <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: begin
          dec_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_sched.sv
// Directed bench for decoder_sched: arbitration order, handshake latency, timeout/no-timeout, reset abort.
module tb_decoder_sched;

  localparam int N_REQ   = 4;
  localparam int DW      = 7;
  localparam int TIMEOUT = 15;

  logic                clock = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       dec_data;
  logic                dec_req;
  logic                dec_ack;
  logic [1:0]          grant_id;
  logic                busy;
  logic                err;

  int   checks    = 0;
  int   errors    = 0;
  logic multi_hot = 1'b0;

  always #5 clock = ~clock;

  decoder_sched #(
    .N_REQ  (N_REQ),
    .DW     (DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .dec_data (dec_data),
    .dec_req  (dec_req),
    .dec_ack  (dec_ack),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  always @(negedge clock) begin
    if ($countones(req_ready) > 1) multi_hot = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Raise ack mid-cycle, expect dec_req low on the third rising edge (two sync edges + FSM edge);
  // drop ack the same way and expect busy low on the third edge. Returns in the IDLE cycle.
  task automatic ack_cycle();
    int n;
    @(negedge clock);
    dec_ack = 1'b1;
    n = 0;
    do begin step(); n++; end while (dec_req && n < 10);
    check("ack_rise_latency", n, 3);
    @(negedge clock);
    dec_ack = 1'b0;
    n = 0;
    do begin step(); n++; end while (busy && n < 10);
    check("ack_fall_latency", n, 3);
  endtask

  initial begin
    int   n;
    logic dropped;

    rst_n     = 1'b0;
    req_valid = '0;
    dec_ack   = 1'b0;
    req_data  = {7'h33, 7'h12, 7'h11, 7'h7D};
    repeat (3) @(posedge clock);
    #1;
    check("rst_dec_req", dec_req, 1'b0);
    check("rst_dec_data", dec_data, 7'h00);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_req_ready", req_ready, 4'b0000);
    rst_n = 1'b1;
    step();

    // Requesters 0 and 2: 0 wins first, 2 right after the handshake closes.
    req_valid = 4'b0101;
    #1;
    check("rr_first", req_ready, 4'b0001);
    step();
    check("g0_grant_id", grant_id, 2'd0);
    check("g0_dec_data", dec_data, 7'h7D);
    check("g0_dec_req", dec_req, 1'b1);
    check("g0_busy", busy, 1'b1);
    check("g0_ready_outside_idle", req_ready, 4'b0000);
    ack_cycle();
    check("rr_second", req_ready, 4'b0100);
    step();
    check("g2_grant_id", grant_id, 2'd2);
    check("g2_dec_data", dec_data, 7'h12);
    check("g2_dec_req", dec_req, 1'b1);
    req_valid = '0;
    ack_cycle();
    check("g2_data_held", dec_data, 7'h12);
    check("g2_id_held", grant_id, 2'd2);

    // Ack three cycles after dec_req rises; explicit edge-by-edge latency.
    req_valid = 4'b1000;
    #1;
    check("rr_req3", req_ready, 4'b1000);
    step();
    req_valid = '0;
    check("g3_grant_id", grant_id, 2'd3);
    check("g3_dec_data", dec_data, 7'h33);
    repeat (3) step();
    check("g3_wait_dec_req", dec_req, 1'b1);
    @(negedge clock);
    dec_ack = 1'b1;
    step();
    check("ack_edge1_dec_req", dec_req, 1'b1);
    step();
    check("ack_edge2_dec_req", dec_req, 1'b1);
    step();
    check("ack_edge3_dec_req", dec_req, 1'b0);
    check("ack_edge3_busy", busy, 1'b1);
    @(negedge clock);
    dec_ack = 1'b0;
    step();
    check("rel_edge1_busy", busy, 1'b1);
    step();
    check("rel_edge2_busy", busy, 1'b1);
    step();
    check("rel_edge3_busy", busy, 1'b0);
    check("g3_data_held", dec_data, 7'h33);

    // Ack glitch in IDLE must do nothing.
    @(negedge clock);
    dec_ack = 1'b1;
    @(negedge clock);
    dec_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("glitch_busy", busy, 1'b0);
      check("glitch_dec_req", dec_req, 1'b0);
    end

    // Ack never arrives.
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    check("hold_grant_id", grant_id, 2'd0);
    check("hold_dec_req", dec_req, 1'b1);
`ifdef DECODER_SCHED_TIMEOUT_EN
    n = 0;
    do begin step(); n++; end while (dec_req && n < 40);
    check("tmo_cycles", n, TIMEOUT);
    check("tmo_err", err, 1'b1);
    check("tmo_busy_rel", busy, 1'b1);
    step();
    check("tmo_idle", busy, 1'b0);
    repeat (5) step();
    check("tmo_err_sticky", err, 1'b1);
`else
    dropped = 1'b0;
    repeat (100) begin
      step();
      if (!dec_req || err) dropped = 1'b1;
    end
    check("no_tmo_dropped", dropped, 1'b0);
    check("no_tmo_dec_req", dec_req, 1'b1);
    check("no_tmo_err", err, 1'b0);
    ack_cycle();
`endif

    // Reset in WAIT_ACK aborts at once; first grant afterwards goes to the lowest valid index.
    req_valid = 4'b0100;
    step();
    check("pre_rst_grant_id", grant_id, 2'd2);
    repeat (2) step();
    check("pre_rst_dec_req", dec_req, 1'b1);
    req_valid = 4'b0110;
    rst_n = 1'b0;
    #1;
    check("rst_async_dec_req", dec_req, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_grant_id", grant_id, 2'd0);
    check("rst_async_err", err, 1'b0);
    @(negedge clock);
    rst_n = 1'b1;
    step();
    check("post_rst_grant_id", grant_id, 2'd1);
    check("post_rst_dec_data", dec_data, 7'h11);
    req_valid = '0;
    ack_cycle();

    // Requester drops before accept: no state change.
    req_valid = 4'b0100;
    #1;
    check("drop_ready", req_ready, 4'b0100);
    #2;
    req_valid = '0;
    step();
    check("drop_busy", busy, 1'b0);
    check("drop_grant_id", grant_id, 2'd1);

    // All four valid across eight handshakes: strict rotation from 0.
    rst_n = 1'b0;
    #1;
    @(negedge clock);
    rst_n = 1'b1;
    step();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rot_ready", req_ready, 4'b0001 << (i % 4));
      step();
      check("rot_grant_id", grant_id, i % 4);
      ack_cycle();
    end
    req_valid = '0;
    step();
    check("ready_never_multi_hot", multi_hot, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
